// File: rtl/maze_path_sequencer.sv
// Sequencer between the maze solver and the direction stack: turns advance/backtrack
// requests into single-cycle stack strobes and replays the stored path as a stream.
module maze_path_sequencer #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_req,
  input  logic [WIDTH-1:0] adv_dir,
  input  logic             back_req,
  input  logic             dump_req,
  output logic             op_ack,
  output logic             op_err,
  output logic [WIDTH-1:0] back_dir,
  output logic [CNT_W-1:0] move_cnt,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_read,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_poped,
  input  logic [WIDTH-1:0] stk_pout,
  input  logic             stk_empty,
  input  logic             stk_full,
  input  logic             stk_all_read,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_dir,
  output logic             out_last,
  input  logic             out_ready,
  output logic             dump_done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  typedef enum logic [3:0] {
    StIdle,
    StPush,
    StPop,
    StPopWait,
    StAck,
    StRead,
    StReadWait,
    StEmit,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] back_dir_q, back_dir_d;
  logic [WIDTH-1:0] out_dir_q, out_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      din_q      <= '0;
      back_dir_q <= '0;
      out_dir_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      din_q      <= din_d;
      back_dir_q <= back_dir_d;
      out_dir_q  <= out_dir_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    din_d      = din_q;
    back_dir_d = back_dir_q;
    out_dir_d  = out_dir_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Priority: dump > backtrack > advance.
        if (dump_req) begin
          state_d = stk_empty ? StDone : StRead;
        end else if (back_req) begin
          err_d   = stk_empty;
          state_d = stk_empty ? StAck : StPop;
        end else if (adv_req) begin
          err_d = stk_full;
          if (stk_full) begin
            state_d = StAck;
          end else begin
            din_d   = adv_dir;
            state_d = StPush;
          end
        end
      end
      StPush: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        state_d = StAck;
      end
      StPop: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        state_d = StPopWait;
      end
      StPopWait: begin
        back_dir_d = stk_poped;
        state_d    = StAck;
      end
      StAck:      state_d = StIdle;
      StRead:     state_d = StReadWait;
      StReadWait: begin
        out_dir_d = stk_pout;
        state_d   = StEmit;
      end
      StEmit: begin
        if (out_ready) state_d = stk_all_read ? StDone : StRead;
      end
      StDone:     state_d = StDone;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    op_ack    = (state_q == StAck);
    op_err    = (state_q == StAck) & err_q;
    stk_push  = (state_q == StPush);
    stk_pop   = (state_q == StPop);
    stk_read  = (state_q == StRead);
    out_valid = (state_q == StEmit);
    out_last  = (state_q == StEmit) & stk_all_read;
    dump_done = (state_q == StDone);
  end

  assign stk_din  = din_q;
  assign back_dir = back_dir_q;
  assign out_dir  = out_dir_q;
  assign move_cnt = cnt_q;

endmodule

// File: tb/tb_maze_path_sequencer.sv
// Randomized bench for maze_path_sequencer: a behavioural stack drives the stack ports and
// a queue holding the expected path predicts acks, errors, depth and the replay stream.
module tb_maze_path_sequencer;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             adv_req, back_req, dump_req, out_ready;
  logic [WIDTH-1:0] adv_dir;
  logic             op_ack, op_err, stk_push, stk_pop, stk_read;
  logic [WIDTH-1:0] back_dir, stk_din, out_dir;
  logic [CNT_W-1:0] move_cnt;
  logic [WIDTH-1:0] stk_poped, stk_pout;
  logic             stk_empty, stk_full, stk_all_read;
  logic             out_valid, out_last, dump_done;

  maze_path_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .adv_req      (adv_req),
    .adv_dir      (adv_dir),
    .back_req     (back_req),
    .dump_req     (dump_req),
    .op_ack       (op_ack),
    .op_err       (op_err),
    .back_dir     (back_dir),
    .move_cnt     (move_cnt),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_read     (stk_read),
    .stk_din      (stk_din),
    .stk_poped    (stk_poped),
    .stk_pout     (stk_pout),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .stk_all_read (stk_all_read),
    .out_valid    (out_valid),
    .out_dir      (out_dir),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .dump_done    (dump_done)
  );

  always #5 clk = ~clk;

  // Behavioural direction stack with registered pop/read data.
  logic [WIDTH-1:0] mem [DEPTH];
  int unsigned      head, rd_ptr;
  assign stk_empty    = (head == 0);
  assign stk_full     = (head == DEPTH);
  assign stk_all_read = (rd_ptr == head);

  always @(posedge clk) begin
    if (rst) begin
      head      <= 0;
      rd_ptr    <= 0;
      stk_poped <= '0;
      stk_pout  <= '0;
    end else begin
      if (stk_push && head < DEPTH) begin
        mem[head] <= stk_din;
        head      <= head + 1;
      end
      if (stk_pop && head > 0) begin
        stk_poped <= mem[head-1];
        head      <= head - 1;
      end
      if (stk_read && rd_ptr < head) begin
        stk_pout <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] path_q [$];
  logic [WIDTH-1:0] bd_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    adv_req   = 1'b0;
    back_req  = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    adv_dir   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    path_q.delete();
    bd_model = '0;
  endtask

  task automatic do_op(input bit adv, input bit back, input logic [WIDTH-1:0] dir);
    int               cyc = 0;
    int               pushes = 0;
    int               pops = 0;
    bit               got = 0;
    bit               exp_err;
    int               exp_lat;
    logic [WIDTH-1:0] din_seen = '0;
    if (back) begin
      exp_err = (path_q.size() == 0);
      exp_lat = exp_err ? 1 : 3;
      if (!exp_err) bd_model = path_q.pop_back();
    end else begin
      exp_err = (path_q.size() == DEPTH);
      exp_lat = exp_err ? 1 : 2;
      if (!exp_err) path_q.push_back(dir);
    end
    @(negedge clk);
    adv_req  = adv;
    back_req = back;
    adv_dir  = dir;
    while (!got && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (stk_push) begin
        pushes++;
        din_seen = stk_din;
      end
      if (stk_pop) pops++;
      if (op_ack) got = 1;
    end
    adv_req  = 1'b0;
    back_req = 1'b0;
    check("ack_seen", 32'(got), 1);
    check("ack_latency", cyc, exp_lat);
    check("op_err", 32'(op_err), 32'(exp_err));
    check("back_dir", 32'(back_dir), 32'(bd_model));
    check("move_cnt", 32'(move_cnt), path_q.size());
    check("push_count", pushes, (!back && !exp_err) ? 1 : 0);
    check("pop_count", pops, (back && !exp_err) ? 1 : 0);
    if (pushes == 1) check("stk_din", 32'(din_seen), 32'(dir));
    @(posedge clk);
  endtask

  task automatic do_dump(input bit rnd_ready);
    int  cyc = 0;
    int  k = 0;
    int  nb = 0;
    bit  done = 0;
    bit  rdy;
    @(negedge clk);
    dump_req = 1'b1;
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (dump_done) begin
        done = 1;
      end else begin
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : (k % 4 != 1);
        k++;
        out_ready = rdy;
        if (out_valid && rdy) begin
          if (nb < path_q.size()) begin
            check("out_dir", 32'(out_dir), 32'(path_q[nb]));
            check("out_last", 32'(out_last), (nb == path_q.size() - 1) ? 1 : 0);
          end
          nb++;
        end
      end
    end
    out_ready = 1'b0;
    check("dump_done", 32'(done), 1);
    check("beat_count", nb, path_q.size());
    check("valid_in_done", 32'(out_valid), 0);
  endtask

  task automatic check_ignored_after_done();
    int acks = 0;
    int strobes = 0;
    @(negedge clk);
    adv_req = 1'b1;
    adv_dir = 2'b11;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (op_ack) acks++;
      if (stk_push || stk_pop || stk_read) strobes++;
    end
    adv_req = 1'b0;
    check("done_no_ack", acks, 0);
    check("done_no_strobe", strobes, 0);
    check("done_held", 32'(dump_done), 1);
  endtask

  initial begin
    int kind;
    do_reset();
    // Reset state.
    check("rst_op_ack", 32'(op_ack), 0);
    check("rst_op_err", 32'(op_err), 0);
    check("rst_strobes", 32'({stk_push, stk_pop, stk_read}), 0);
    check("rst_out", 32'({out_valid, out_last, dump_done}), 0);
    check("rst_move_cnt", 32'(move_cnt), 0);
    check("rst_dirs", 32'({back_dir, out_dir, stk_din}), 0);

    do_op(0, 1, 2'b00);  // underflow
    do_op(1, 0, 2'b01);
    do_op(1, 0, 2'b11);
    do_op(1, 0, 2'b00);
    do_op(1, 0, 2'b10);
    do_op(0, 1, 2'b00);  // expect 2'b10 back

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      do_op(kind < 5 || kind == 9, kind >= 5, WIDTH'($urandom));
    end

    // Reset while in POP_WAIT aborts the backtrack with no ack.
    if (path_q.size() == 0) do_op(1, 0, 2'b01);
    @(negedge clk);
    back_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    back_req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_ack", 32'(op_ack), 0);
    check("abort_move_cnt", 32'(move_cnt), 0);
    check("abort_strobes", 32'({stk_push, stk_pop, stk_read}), 0);
    @(negedge clk);
    rst = 1'b0;
    path_q.delete();
    bd_model = '0;
    do_op(1, 0, 2'b10);

    // Fill to capacity, overflow, then simultaneous requests pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, WIDTH'($urandom));
    do_op(1, 0, 2'b01);
    do_op(1, 1, 2'b01);

    // Replay 1,2,3 with a 1,0,1,1 ready pattern.
    do_reset();
    do_op(1, 0, 2'b01);
    do_op(1, 0, 2'b10);
    do_op(1, 0, 2'b11);
    do_dump(0);
    check_ignored_after_done();

    // Random-length replay with random ready.
    do_reset();
    for (int i = 0; i < 9; i++) do_op(1, 0, WIDTH'($urandom));
    do_op(0, 1, 2'b00);
    do_dump(1);

    // Replay of an empty stack goes straight to DONE.
    do_reset();
    do_dump(1);
    check_ignored_after_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
